// File: rtl/mod_exp_pkg.sv
// Shared types and default widths for the modular exponentiation controller.
package mod_exp_pkg;

  localparam int BIT_LEN_DEF = 64;
  localparam int EXP_LEN_DEF = 64;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SQR,
    ST_SQR_WAIT,
    ST_MUL,
    ST_MUL_WAIT,
    ST_CONV,
    ST_CONV_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mod_exp_reduce.sv
// Combinational final subtraction: maps a Montgomery product below 2M into [0, M).
module mod_exp_reduce #(
  parameter int bitLen = 64
) (
  input  logic [bitLen:0]   p,
  input  logic [bitLen-1:0] m,
  output logic [bitLen-1:0] r
);

  logic ge;

  assign ge = (p >= {1'b0, m});
  // p < 2M, so the difference always fits in bitLen bits
  assign r  = ge ? (p[bitLen-1:0] - m) : p[bitLen-1:0];

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller sequencing an external mon_prod unit.
// MOD_EXP_LEADING_ZERO_SKIP_EN: when defined, squarings are skipped until the first exponent 1 bit.
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int bitLen     = BIT_LEN_DEF,
  parameter int countWidth = 5,
  parameter int expLen     = EXP_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [bitLen-1:0]     X_mont,
  input  logic [bitLen-1:0]     one_mont,
  input  logic [expLen-1:0]     E,
  input  logic [bitLen-1:0]     M,
  input  logic [countWidth-1:0] num_words,
  output logic                  busy,
  output logic                  done,
  output logic [bitLen-1:0]     result,
  output logic [15:0]           op_count,
  output logic                  mp_start,
  output logic [bitLen-1:0]     mp_A,
  output logic [bitLen-1:0]     mp_B,
  output logic [bitLen-1:0]     mp_M,
  output logic [countWidth-1:0] mp_num_words,
  input  logic                  mp_stop,
  input  logic [bitLen:0]       mp_P
);

  localparam int IdxW = (expLen > 1) ? $clog2(expLen) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(expLen - 1);

  state_t            state;
  logic [bitLen-1:0] x_q;
  logic [bitLen-1:0] acc;
  logic [bitLen-1:0] acc_red;
  logic [expLen-1:0] e_q;
  logic [IdxW-1:0]   bit_idx;
  logic              skip_sqr;
  logic              stop_seen;
  logic              last_bit;
  logic              cur_bit;

  mod_exp_reduce #(.bitLen(bitLen)) u_reduce (
    .p (mp_P),
    .m (mp_M),
    .r (acc_red)
  );

`ifdef MOD_EXP_LEADING_ZERO_SKIP_EN
  // While no 1 bit has been processed, acc is still one_mont and squaring it is a no-op
  logic seen_one;

  always_ff @(posedge clk) begin
    if (reset || state == ST_LOAD) begin
      seen_one <= 1'b0;
    end else if (state == ST_MUL) begin
      seen_one <= 1'b1;
    end
  end

  assign skip_sqr = !seen_one;
`else
  assign skip_sqr = 1'b0;
`endif

  // mp_start is registered, so it is high exactly in the launch cycle of a WAIT state
  assign stop_seen = mp_stop && !mp_start;
  assign last_bit  = (bit_idx == '0);
  assign cur_bit   = e_q[bit_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
      op_count     <= '0;
      mp_start     <= 1'b0;
      mp_A         <= '0;
      mp_B         <= '0;
      mp_M         <= '0;
      mp_num_words <= '0;
      x_q          <= '0;
      e_q          <= '0;
      acc          <= '0;
      bit_idx      <= '0;
    end else begin
      done     <= 1'b0;
      mp_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          x_q          <= X_mont;
          e_q          <= E;
          mp_M         <= M;
          mp_num_words <= num_words;
          acc          <= one_mont;
          bit_idx      <= IdxTop;
          op_count     <= '0;
          state        <= ST_SQR;
        end
        ST_SQR: begin
          if (skip_sqr) begin
            if (cur_bit) begin
              state <= ST_MUL;
            end else if (last_bit) begin
              state <= ST_CONV;
            end else begin
              bit_idx <= bit_idx - 1'b1;
            end
          end else begin
            mp_start <= 1'b1;
            mp_A     <= acc;
            mp_B     <= acc;
            op_count <= op_count + 16'd1;
            state    <= ST_SQR_WAIT;
          end
        end
        ST_SQR_WAIT: begin
          if (stop_seen) begin
            acc <= acc_red;
            if (cur_bit) begin
              state <= ST_MUL;
            end else if (last_bit) begin
              state <= ST_CONV;
            end else begin
              bit_idx <= bit_idx - 1'b1;
              state   <= ST_SQR;
            end
          end
        end
        ST_MUL: begin
          mp_start <= 1'b1;
          mp_A     <= acc;
          mp_B     <= x_q;
          op_count <= op_count + 16'd1;
          state    <= ST_MUL_WAIT;
        end
        ST_MUL_WAIT: begin
          if (stop_seen) begin
            acc <= acc_red;
            if (last_bit) begin
              state <= ST_CONV;
            end else begin
              bit_idx <= bit_idx - 1'b1;
              state   <= ST_SQR;
            end
          end
        end
        ST_CONV: begin
          // Multiplying by plain 1 strips the R factor
          mp_start <= 1'b1;
          mp_A     <= acc;
          mp_B     <= bitLen'(1);
          op_count <= op_count + 16'd1;
          state    <= ST_CONV_WAIT;
        end
        ST_CONV_WAIT: begin
          if (stop_seen) begin
            acc   <= acc_red;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          result <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl with a behavioural bit-serial Montgomery multiplier.
module tb_mod_exp_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] X_mont;
  logic [63:0] one_mont;
  logic [63:0] E;
  logic [63:0] M;
  logic [4:0]  num_words;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic [15:0] op_count;
  logic        mp_start;
  logic [63:0] mp_A;
  logic [63:0] mp_B;
  logic [63:0] mp_M;
  logic [4:0]  mp_num_words;
  logic        mp_stop;
  logic [64:0] mp_P;

  int checks    = 0;
  int failures  = 0;
  int proto_err = 0;

  always #5 clk = ~clk;

  mod_exp_ctrl #(.bitLen(64), .countWidth(5), .expLen(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .X_mont       (X_mont),
    .one_mont     (one_mont),
    .E            (E),
    .M            (M),
    .num_words    (num_words),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .op_count     (op_count),
    .mp_start     (mp_start),
    .mp_A         (mp_A),
    .mp_B         (mp_B),
    .mp_M         (mp_M),
    .mp_num_words (mp_num_words),
    .mp_stop      (mp_stop),
    .mp_P         (mp_P)
  );

  // a*b*2^-64 mod m, left in [0, 2m)
  function automatic logic [64:0] mont(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m);
    logic [65:0] p;
    p = '0;
    for (int i = 0; i < 64; i++) begin
      if (a[i]) p = p + {2'b00, b};
      if (p[0]) p = p + {2'b00, m};
      p = p >> 1;
    end
    return p[64:0];
  endfunction

  function automatic logic [63:0] to_mont(input logic [63:0] x, input logic [63:0] m);
    logic [64:0] r;
    r = {1'b0, x % m};
    for (int i = 0; i < 64; i++) begin
      r = r << 1;
      if (r >= {1'b0, m}) r = r - {1'b0, m};
    end
    return r[63:0];
  endfunction

  function automatic logic [63:0] ref_pow(input logic [63:0] x, input logic [63:0] e, input logic [63:0] m);
    logic [127:0] r;
    logic [127:0] b;
    logic [127:0] mm;
    mm = {64'd0, m};
    r  = 128'd1 % mm;
    b  = {64'd0, x} % mm;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * b) % mm;
      b = (b * b) % mm;
    end
    return r[63:0];
  endfunction

  function automatic int exp_ops(input logic [63:0] e);
    int pc;
    int msb;
    pc  = $countones(e);
    msb = 0;
    for (int i = 0; i < 64; i++) if (e[i]) msb = i;
`ifdef MOD_EXP_LEADING_ZERO_SKIP_EN
    return msb + pc + 1;
`else
    return 64 + pc + 1 + (msb - msb);
`endif
  endfunction

  // Behavioural mon_prod: answers each launch after 1..4 extra cycles
  initial begin : mon_prod_model
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] m;
    mp_stop = 1'b0;
    mp_P    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mp_start && !reset) begin
        a = mp_A;
        b = mp_B;
        m = mp_M;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        mp_P    = mont(a, b, m);
        mp_stop = 1'b1;
        @(posedge clk);
        #1;
        mp_stop = 1'b0;
        mp_P    = {1'b0, $urandom(), $urandom()};
      end
    end
  end

  // Protocol monitor: no back-to-back launches, operands frozen while a product is outstanding
  logic        prev_start = 1'b0;
  logic        pend = 1'b0;
  logic [63:0] snap_a, snap_b, snap_m;
  always @(negedge clk) begin
    if (reset || !busy) begin
      pend       = 1'b0;
      prev_start = 1'b0;
    end else begin
      if (prev_start && mp_start) proto_err++;
      if (mp_start) begin
        snap_a = mp_A;
        snap_b = mp_B;
        snap_m = mp_M;
        pend   = 1'b1;
      end else if (pend) begin
        if (mp_A !== snap_a || mp_B !== snap_b || mp_M !== snap_m) proto_err++;
        if (mp_stop) pend = 1'b0;
      end
      prev_start = mp_start;
    end
  end

  task automatic run_exp(input logic [63:0] x, input logic [63:0] e, input logic [63:0] m,
                         input logic [4:0] nw, input bit repulse,
                         output logic [63:0] res, output logic [15:0] ops, output int ndone,
                         output logic busy_early, output logic busy_done,
                         output logic [4:0] nw_seen, output bit timeout);
    bit got;
    int post;
    X_mont    = to_mont(x, m);
    one_mont  = to_mont(64'd1, m);
    E         = e;
    M         = m;
    num_words = nw;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    busy_early = busy;
    got = 0; post = 0; ndone = 0;
    res = '0; ops = '0; busy_done = 1'b1; nw_seen = '0;
    for (int i = 0; i < 20000 && !(got && post >= 3); i++) begin
      @(negedge clk);
      if (repulse && i == 4) begin
        X_mont   = ~X_mont;
        one_mont = '0;
        E        = '1;
        M        = 64'd1001;
        start    = 1'b1;
      end
      if (repulse && i == 5) start = 1'b0;
      if (i == 1) nw_seen = mp_num_words;
      if (done) begin
        ndone++;
        if (!got) begin
          res       = result;
          ops       = op_count;
          busy_done = busy;
        end
        got = 1;
      end else if (got) begin
        post++;
      end
    end
    timeout = !got;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (mp_start !== 1'b0) begin failures++; $display("FAIL reset_mp_start got=%0b exp=0", mp_start); end
    checks++; if (result !== 64'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
    checks++; if (op_count !== 16'd0) begin failures++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    checks++; if ({mp_A, mp_B, mp_M} !== 192'd0) begin failures++; $display("FAIL reset_operands A=%0d B=%0d M=%0d exp=0", mp_A, mp_B, mp_M); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [63:0] res; logic [15:0] ops; int nd; logic be, bd; logic [4:0] nws; bit to;
    run_exp(64'd5, 64'd3, 64'd253, 5'd3, 0, res, ops, nd, be, bd, nws, to);
    checks++; if (to) begin failures++; $display("FAIL e3_timeout no done within budget"); end
    checks++; if (res !== 64'd125) begin failures++; $display("FAIL e3_result got=%0d exp=125", res); end
    checks++; if (ops !== 16'(exp_ops(64'd3))) begin failures++; $display("FAIL e3_op_count got=%0d exp=%0d", ops, exp_ops(64'd3)); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL e3_done_pulses got=%0d exp=1", nd); end
    checks++; if (be !== 1'b1) begin failures++; $display("FAIL e3_busy_after_start got=%0b exp=1", be); end
    checks++; if (bd !== 1'b0) begin failures++; $display("FAIL e3_busy_at_done got=%0b exp=0", bd); end
    checks++; if (nws !== 5'd3) begin failures++; $display("FAIL e3_num_words got=%0d exp=3", nws); end
    run_exp(64'd216, 64'd2, 64'd253, 5'd7, 0, res, ops, nd, be, bd, nws, to);
    checks++; if (res !== 64'd104) begin failures++; $display("FAIL e2_result got=%0d exp=104", res); end
    checks++; if (ops !== 16'(exp_ops(64'd2))) begin failures++; $display("FAIL e2_op_count got=%0d exp=%0d", ops, exp_ops(64'd2)); end
    run_exp(64'd5, 64'd0, 64'd253, 5'd1, 0, res, ops, nd, be, bd, nws, to);
    checks++; if (res !== 64'd1) begin failures++; $display("FAIL e0_result got=%0d exp=1", res); end
    checks++; if (ops !== 16'(exp_ops(64'd0))) begin failures++; $display("FAIL e0_op_count got=%0d exp=%0d", ops, exp_ops(64'd0)); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL e0_done_pulses got=%0d exp=1", nd); end
  endtask

  task automatic test_busy_ignore();
    logic [63:0] res; logic [15:0] ops; int nd; logic be, bd; logic [4:0] nws; bit to;
    run_exp(64'd5, 64'd1, 64'd253, 5'd9, 1, res, ops, nd, be, bd, nws, to);
    checks++; if (res !== 64'd5) begin failures++; $display("FAIL repulse_result got=%0d exp=5", res); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL repulse_done_pulses got=%0d exp=1", nd); end
    checks++; if (ops !== 16'(exp_ops(64'd1))) begin failures++; $display("FAIL repulse_op_count got=%0d exp=%0d", ops, exp_ops(64'd1)); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL repulse_busy_after got=%0b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res; logic [15:0] ops; int nd; logic be, bd; logic [4:0] nws; bit to;
    logic [63:0] xm;
    bit found;
    int stray;
    xm        = to_mont(64'd5, 64'd253);
    X_mont    = xm;
    one_mont  = to_mont(64'd1, 64'd253);
    E         = 64'd3;
    M         = 64'd253;
    num_words = 5'd4;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      if (mp_start && mp_B == xm) found = 1;
    end
    checks++; if (!found) begin failures++; $display("FAIL rmid_mul_launch not seen within budget"); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
    checks++; if (mp_start !== 1'b0) begin failures++; $display("FAIL rmid_mp_start got=%0b exp=0", mp_start); end
    checks++; if (result !== 64'd0) begin failures++; $display("FAIL rmid_result got=%0d exp=0", result); end
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    checks++; if (stray !== 0) begin failures++; $display("FAIL rmid_stray_activity got=%0d exp=0", stray); end
    run_exp(64'd216, 64'd2, 64'd253, 5'd2, 0, res, ops, nd, be, bd, nws, to);
    checks++; if (res !== 64'd104) begin failures++; $display("FAIL rmid_restart_result got=%0d exp=104", res); end
    checks++; if (ops !== 16'(exp_ops(64'd2))) begin failures++; $display("FAIL rmid_restart_op_count got=%0d exp=%0d", ops, exp_ops(64'd2)); end
  endtask

  task automatic test_random();
    logic [63:0] res; logic [15:0] ops; int nd; logic be, bd; logic [4:0] nws; bit to;
    logic [63:0] m, x, e, exp_r;
    logic [4:0]  nw;
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) m = {$urandom(), $urandom()} | 64'd1;
      else            m = 64'($urandom_range(1, 32767)) * 64'd2 + 64'd1;
      if (m < 64'd3) m = 64'd3;
      x  = {$urandom(), $urandom()} % m;
      e  = (k % 3 == 0) ? 64'($urandom_range(0, 255)) : {$urandom(), $urandom()};
      nw = 5'($urandom_range(1, 31));
      exp_r = ref_pow(x, e, m);
      run_exp(x, e, m, nw, 0, res, ops, nd, be, bd, nws, to);
      checks++; if (res !== exp_r) begin failures++; $display("FAIL rand%0d_result m=%0d x=%0d e=%0h got=%0d exp=%0d", k, m, x, e, res, exp_r); end
      checks++; if (ops !== 16'(exp_ops(e))) begin failures++; $display("FAIL rand%0d_op_count got=%0d exp=%0d", k, ops, exp_ops(e)); end
      checks++; if (nws !== nw) begin failures++; $display("FAIL rand%0d_num_words got=%0d exp=%0d", k, nws, nw); end
    end
  endtask

  task automatic test_protocol();
    checks++; if (proto_err !== 0) begin failures++; $display("FAIL protocol_violations got=%0d exp=0", proto_err); end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    X_mont    = '0;
    one_mont  = '0;
    E         = '0;
    M         = '0;
    num_words = '0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
